// File: rtl/datapath_pkg.sv
// Shared types for the single-bus datapath: opcodes, sequencer states,
// internal bus source indices and debug-peek offsets.
package datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_NEG  = 4'd6,
    OP_NOT  = 4'd7,
    OP_MUL  = 4'd8,
    OP_LD   = 4'd9,
    OP_ADDI = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_OPA, S_OPB, S_WBLO, S_WBHI, S_MAR, S_MEMRD, S_WBMEM
  } state_e;

  // One-hot bus source positions
  localparam int BUS_RB  = 0;
  localparam int BUS_RC  = 1;
  localparam int BUS_IMM = 2;
  localparam int BUS_ZLO = 3;
  localparam int BUS_ZHI = 4;
  localparam int BUS_MDR = 5;
  localparam int BUS_N   = 6;

  // dbg_sel codes for HI/LO are NUM_REGS plus these offsets
  localparam int DBG_HI_OFS = 0;
  localparam int DBG_LO_OFS = 1;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: A is the Y register, B is the bus; result is 2*DATA_W so
// MUL can return HI:LO in one word.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  op_e                 op_i,
  input  logic [SHW-1:0]      shamt_i,
  output logic [2*DATA_W-1:0] res_o
);

  logic signed [2*DATA_W-1:0] a_x, b_x;

  always_comb begin
    a_x   = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    b_x   = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    res_o = '0;
    case (op_i)
      OP_ADD, OP_LD, OP_ADDI: res_o[DATA_W-1:0] = a_i + b_i;
      OP_SUB:                 res_o[DATA_W-1:0] = a_i - b_i;
      OP_AND:                 res_o[DATA_W-1:0] = a_i & b_i;
      OP_OR:                  res_o[DATA_W-1:0] = a_i | b_i;
      OP_SHR:                 res_o[DATA_W-1:0] = a_i >> shamt_i;
      OP_SHL:                 res_o[DATA_W-1:0] = a_i << shamt_i;
      // NEG/NOT operate on Rb, which sits in Y by the time the ALU runs
      OP_NEG:                 res_o[DATA_W-1:0] = '0 - a_i;
      OP_NOT:                 res_o[DATA_W-1:0] = ~a_i;
      OP_MUL:                 res_o = a_x * b_x;
      default:                res_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, HI/LO, Y, Z, MAR, MDR and the
// micro-step sequencer that runs one command per handshake.
module bus_datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [REG_AW-1:0] cmd_rc,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [REG_AW:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SHW = $clog2(DATA_W);
  localparam logic [REG_AW:0] SEL_HI = (REG_AW+1)'(NUM_REGS + DBG_HI_OFS);
  localparam logic [REG_AW:0] SEL_LO = (REG_AW+1)'(NUM_REGS + DBG_LO_OFS);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   hi_q, lo_q, y_q, mar_q, mdr_q;
  logic [2*DATA_W-1:0] z_q;
  logic                rsp_valid_q, rsp_err_q, mem_rd_q;
  logic [DATA_W-1:0]   rsp_result_q;

  logic                accept, legal, illegal_acc;
  logic                rsp_done, rf_we;
  logic [BUS_N-1:0]    bus_sel;
  logic [DATA_W-1:0]   bus, rb_val, rc_val, result_val;
  logic [2*DATA_W-1:0] alu_res;

  assign accept      = cmd_valid && (state_q == S_IDLE);
  assign legal       = op_legal(cmd_op);
  assign illegal_acc = accept && !legal;

  assign rb_val = (R0_ZERO && rb_q == '0) ? '0 : rf_q[rb_q];
  assign rc_val = (R0_ZERO && rc_q == '0) ? '0 : rf_q[rc_q];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rsp_done = 1'b0;
    rf_we    = 1'b0;
    bus_sel  = '0;
    case (state_q)
      S_IDLE:  if (accept && legal) state_d = S_OPA;
      S_OPA: begin
        bus_sel[BUS_RB] = 1'b1;
        state_d = S_OPB;
      end
      S_OPB: begin
        if (op_q == OP_LD || op_q == OP_ADDI) bus_sel[BUS_IMM] = 1'b1;
        else                                  bus_sel[BUS_RC]  = 1'b1;
        state_d = (op_q == OP_LD) ? S_MAR : S_WBLO;
      end
      S_WBLO: begin
        bus_sel[BUS_ZLO] = 1'b1;
        if (op_q == OP_MUL) begin
          state_d = S_WBHI;
        end else begin
          state_d  = S_IDLE;
          rsp_done = 1'b1;
          rf_we    = 1'b1;
        end
      end
      S_WBHI: begin
        bus_sel[BUS_ZHI] = 1'b1;
        state_d  = S_IDLE;
        rsp_done = 1'b1;
      end
      S_MAR: begin
        bus_sel[BUS_ZLO] = 1'b1;
        state_d = S_MEMRD;
      end
      S_MEMRD: if (mem_ack) state_d = S_WBMEM;
      S_WBMEM: begin
        bus_sel[BUS_MDR] = 1'b1;
        state_d  = S_IDLE;
        rsp_done = 1'b1;
        rf_we    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus = ({DATA_W{bus_sel[BUS_RB]}}  & rb_val)
        | ({DATA_W{bus_sel[BUS_RC]}}  & rc_val)
        | ({DATA_W{bus_sel[BUS_IMM]}} & imm_q)
        | ({DATA_W{bus_sel[BUS_ZLO]}} & z_q[DATA_W-1:0])
        | ({DATA_W{bus_sel[BUS_ZHI]}} & z_q[2*DATA_W-1:DATA_W])
        | ({DATA_W{bus_sel[BUS_MDR]}} & mdr_q);
    // MUL reports LO even though the final step drives Zhigh onto the bus
    result_val = (state_q == S_WBHI) ? z_q[DATA_W-1:0] : bus;
  end

  dp_alu #(.DATA_W(DATA_W), .SHW(SHW)) u_alu (
    .a_i    (y_q),
    .b_i    (bus),
    .op_i   (op_q),
    .shamt_i(bus[SHW-1:0]),
    .res_o  (alu_res)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q         <= OP_ADD;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      imm_q        <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      y_q          <= '0;
      z_q          <= '0;
      mar_q        <= '0;
      mdr_q        <= '0;
      mem_rd_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      if (accept && legal) begin
        op_q  <= op_e'(cmd_op);
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        rc_q  <= cmd_rc;
        imm_q <= cmd_imm;
      end
      case (state_q)
        S_OPA:   y_q <= bus;
        S_OPB:   z_q <= alu_res;
        S_WBLO:  if (op_q == OP_MUL) lo_q <= bus;
        S_WBHI:  hi_q <= bus;
        S_MAR: begin
          mar_q    <= bus;
          mem_rd_q <= 1'b1;
        end
        S_MEMRD: if (mem_ack) begin
          mdr_q    <= mem_rdata;
          mem_rd_q <= 1'b0;
        end
        default: ;
      endcase
      if (rf_we && !(R0_ZERO && ra_q == '0)) rf_q[ra_q] <= bus;
      rsp_valid_q <= rsp_done | illegal_acc;
      rsp_err_q   <= illegal_acc;
      if (rsp_done) rsp_result_q <= result_val;
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!dbg_sel[REG_AW])      dbg_data = rf_q[dbg_sel[REG_AW-1:0]];
    else if (dbg_sel == SEL_HI) dbg_data = hi_q;
    else if (dbg_sel == SEL_LO) dbg_data = lo_q;
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_result = rsp_result_q;
  assign mem_addr   = mar_q;
  assign mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: vector table of register ops applied
// back-to-back, then hand sequences for LD with wait states and mid-op clear.
module tb_bus_datapath_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_ra, cmd_rb, cmd_rc;
  logic [31:0] cmd_imm;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  bus_datapath_seq dut (
    .clock     (clock),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rc    (cmd_rc),
    .cmd_imm   (cmd_imm),
    .rsp_valid (rsp_valid),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [31:0] imm;
    logic [31:0] res;
    logic        err;
    int          lat;   // edges after the accepting edge until rsp_valid is seen
    logic [4:0]  sel;
    logic [31:0] dval;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [3:0] rc, input logic [31:0] imm, input logic [31:0] res,
                              input logic err, input int lat, input logic [4:0] sel,
                              input logic [31:0] dval);
    vec_t v;
    v.op = op; v.ra = ra; v.rb = rb; v.rc = rc; v.imm = imm;
    v.res = res; v.err = err; v.lat = lat; v.sel = sel; v.dval = dval;
    return v;
  endfunction

  // Called just after a negedge with the block idle; returns just after the
  // negedge where rsp_valid was seen, so the next call accepts back-to-back.
  task automatic run_cmd(input int idx, input vec_t v);
    int lat;
    string nm;
    nm = $sformatf("v%0d", idx);
    chk({nm, "_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb; cmd_rc = v.rc; cmd_imm = v.imm;
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_ra = 4'hF; cmd_rb = 4'hF; cmd_rc = 4'hF; cmd_imm = 32'hA5A5A5A5;
    cmd_op = 4'd0;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(posedge clock);
      @(negedge clock);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_lat"}, lat, v.lat);
    chk({nm, "_err"}, rsp_err, v.err);
    if (!v.err) chk({nm, "_res"}, rsp_result, v.res);
    dbg_sel = v.sel; #1;
    chk({nm, "_dbg"}, dbg_data, v.dval);
  endtask

  initial begin
    int lat, hi_cnt, waits;
    logic got_rd;

    clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
    cmd_imm = '0; mem_rdata = '0; mem_ack = 1'b0; dbg_sel = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    for (int s = 0; s < 32; s++) begin
      dbg_sel = 5'(s); #0.1;
      chk($sformatf("rst_dbg%0d", s), dbg_data, 32'h0);
    end
    clear = 1'b0;
    @(negedge clock);

    //             op  ra rb rc imm    res           err lat sel dval
    vecs.push_back(mk(10, 1, 0, 0, 5,  32'd5,        0, 3, 1,  32'd5));
    vecs.push_back(mk( 0, 3, 1, 1, 0,  32'd10,       0, 3, 3,  32'd10));
    vecs.push_back(mk(10, 5, 0, 0, 1,  32'd1,        0, 3, 5,  32'd1));
    vecs.push_back(mk( 1, 6, 0, 5, 0,  32'hFFFFFFFF, 0, 3, 6,  32'hFFFFFFFF));
    vecs.push_back(mk(10, 8, 0, 0, 33, 32'd33,       0, 3, 8,  32'd33));
    vecs.push_back(mk( 5, 7, 5, 8, 0,  32'd2,        0, 3, 7,  32'd2));
    vecs.push_back(mk(10,10, 0, 0, 31, 32'd31,       0, 3, 10, 32'd31));
    vecs.push_back(mk( 5, 9, 5,10, 0,  32'h80000000, 0, 3, 9,  32'h80000000));
    vecs.push_back(mk(10,11, 0, 0, 2,  32'd2,        0, 3, 11, 32'd2));
    vecs.push_back(mk( 8, 0, 6,11, 0,  32'hFFFFFFFE, 0, 4, 17, 32'hFFFFFFFE));
    vecs.push_back(mk( 8, 0, 9,11, 0,  32'h00000000, 0, 4, 16, 32'hFFFFFFFF));
    vecs.push_back(mk(10, 0, 1, 0, 7,  32'd12,       0, 3, 0,  32'd0));
    vecs.push_back(mk( 2,12, 6,10, 0,  32'd31,       0, 3, 12, 32'd31));
    vecs.push_back(mk( 3,13, 9, 5, 0,  32'h80000001, 0, 3, 13, 32'h80000001));
    vecs.push_back(mk( 4,14, 6, 8, 0,  32'h7FFFFFFF, 0, 3, 14, 32'h7FFFFFFF));
    vecs.push_back(mk( 6,15,11, 0, 0,  32'hFFFFFFFE, 0, 3, 15, 32'hFFFFFFFE));
    vecs.push_back(mk( 7, 2, 1, 0, 0,  32'hFFFFFFFA, 0, 3, 2,  32'hFFFFFFFA));
    // illegal opcodes answer in the cycle right after the accepting edge
    vecs.push_back(mk(15, 1, 0, 0, 99, 32'd0,        1, 0, 1,  32'd5));
    vecs.push_back(mk(11, 3, 0, 0, 0,  32'd0,        1, 0, 3,  32'd10));
    vecs.push_back(mk( 0, 4, 0, 1, 0,  32'd5,        0, 3, 4,  32'd5));
    vecs.push_back(mk(10, 1, 0, 0, 16, 32'd16,       0, 3, 1,  32'd16));

    foreach (vecs[i]) run_cmd(i, vecs[i]);

    dbg_sel = 5'd17; #1;
    chk("lo_after_mul", dbg_data, 32'h0);
    dbg_sel = 5'd16; #1;
    chk("hi_after_mul", dbg_data, 32'hFFFFFFFF);

    // LD R4 <- mem[R1 + 0x20] with three wait cycles before ack
    chk("ld_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = 4'd9; cmd_ra = 4'd4; cmd_rb = 4'd1; cmd_rc = 4'd0; cmd_imm = 32'h20;
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_imm = 32'h0; cmd_rb = 4'd0;
    lat = -1; hi_cnt = 0; waits = 0; got_rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(posedge clock);
      @(negedge clock);
      mem_ack = 1'b0;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (mem_rd) begin
        hi_cnt++;
        if (!got_rd) chk("ld_mem_addr", mem_addr, 32'h30);
        got_rd = 1'b1;
        if (waits < 3) waits++;
        else begin
          mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        end
      end
    end
    chk("ld_lat", lat, 8);
    chk("ld_rd_cycles", hi_cnt, 4);
    chk("ld_err", rsp_err, 1'b0);
    chk("ld_res", rsp_result, 32'hDEADBEEF);
    dbg_sel = 5'd4; #1;
    chk("ld_r4", dbg_data, 32'hDEADBEEF);
    @(negedge clock);
    chk("ld_pulse", rsp_valid, 1'b0);

    // LD R5 again, then clear while MEMRD waits for an ack that never comes
    cmd_valid = 1'b1; cmd_op = 4'd9; cmd_ra = 4'd5; cmd_rb = 4'd1; cmd_rc = 4'd0; cmd_imm = 32'h0;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    got_rd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (mem_rd) begin
        got_rd = 1'b1;
        break;
      end
    end
    chk("clr_reached_memrd", got_rd, 1'b1);
    #1 clear = 1'b1;
    #1;
    chk("clr_mem_rd", mem_rd, 1'b0);
    chk("clr_ready", cmd_ready, 1'b1);
    @(negedge clock);
    clear = 1'b0;
    got_rd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (rsp_valid) got_rd = 1'b1;
    end
    chk("clr_no_rsp", got_rd, 1'b0);
    dbg_sel = 5'd1; #1;
    chk("clr_r1", dbg_data, 32'h0);
    dbg_sel = 5'd5; #1;
    chk("clr_r5", dbg_data, 32'h0);
    dbg_sel = 5'd16; #1;
    chk("clr_hi", dbg_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
